// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection for a fetch front end. It holds a registered
// PC, a one-entry slot for a redirect that arrives while stalled, and a small
// circular return-address stack that silently overwrites its oldest entry
// when it overflows.
module pc_sequencer #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h0000_0100),
    parameter int unsigned     RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            preset,
    input  logic [XLEN-1:0] starting_addr,
    input  logic            trap,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow
);

    localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  stack [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_up;
    logic [CNT_W-1:0] count;
    logic             pend_valid;
    logic [XLEN-1:0]  pend_target;

    logic advance;   // normal sequencing this cycle (no reset/preset/trap/stall)
    logic push_en;
    logic pop_sel;   // pop reached in the priority chain
    logic pop_en;    // pop actually removes an entry

    assign pc_plus4   = pc_out + XLEN'(4);
    assign misaligned = (pc_out[1:0] != 2'b00);
    assign ras_empty  = (count == '0);
    assign ras_full   = (count == CNT_FULL);

    // Decode which stack operations take effect this cycle.
    always_comb begin
        advance = !reset && !preset && !trap && !stall;
        push_en = advance && ras_push;
        pop_sel = advance && ras_pop && !redirect_valid && !pend_valid;
        pop_en  = pop_sel && !ras_empty;
        top_up  = top + PTR_W'(1);
    end

    // Stack storage; a push with a pop replaces the top in place, otherwise
    // the push lands one slot above (wrapping onto the oldest when full).
    always_ff @(posedge clk) begin
        if (push_en) begin
            if (pop_en) stack[top]    <= pc_plus4;
            else        stack[top_up] <= pc_plus4;
        end
    end

    // PC, pending redirect, stack pointer/occupancy and underflow pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out        <= RESET_ADDR;
            top           <= '0;
            count         <= '0;
            pend_valid    <= 1'b0;
            pend_target   <= '0;
            ras_underflow <= 1'b0;
        end else if (preset) begin
            pc_out        <= starting_addr;
            count         <= '0;
            pend_valid    <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (trap) begin
            pc_out        <= TRAP_VEC;
            pend_valid    <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (stall) begin
            ras_underflow <= 1'b0;
            // Latest stalled redirect wins the pending slot.
            if (redirect_valid) begin
                pend_valid  <= 1'b1;
                pend_target <= redirect_target;
            end
        end else begin
            pend_valid    <= 1'b0;
            ras_underflow <= pop_sel && ras_empty;

            if (redirect_valid)  pc_out <= redirect_target;
            else if (pend_valid) pc_out <= pend_target;
            else if (pop_en)     pc_out <= stack[top];
            else                 pc_out <= pc_plus4;

            if (push_en && !pop_en) begin
                top <= top_up;
                if (!ras_full) count <= count + CNT_W'(1);
            end else if (pop_en && !push_en) begin
                top   <= top - PTR_W'(1);
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus a randomized run, all checked
// against a queue-based model of the PC / return-stack behaviour.
module tb_pc_sequencer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_A = 32'h0;
    localparam logic [31:0] TRP_A = 32'h100;

    logic        clk;
    logic        reset, preset, trap, stall, redirect_valid, ras_push, ras_pop;
    logic [31:0] starting_addr, redirect_target;
    logic [31:0] pc_out, pc_plus4;
    logic        misaligned, ras_empty, ras_full, ras_underflow;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    logic        m_pv;
    logic [31:0] m_pt;
    logic        m_uf;

    pc_sequencer #(
        .XLEN(32), .RESET_ADDR(RST_A), .TRAP_VEC(TRP_A), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .preset(preset), .starting_addr(starting_addr),
        .trap(trap), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .ras_push(ras_push), .ras_pop(ras_pop),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .misaligned(misaligned),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next-state of the architectural behaviour from the current inputs.
    task automatic model_step();
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        if (reset) begin
            m_pc = RST_A; m_stk.delete(); m_pv = 0; m_uf = 0;
        end else if (preset) begin
            m_pc = starting_addr; m_stk.delete(); m_pv = 0; m_uf = 0;
        end else if (trap) begin
            m_pc = TRP_A; m_pv = 0; m_uf = 0;
        end else if (stall) begin
            m_uf = 0;
            if (redirect_valid) begin m_pv = 1; m_pt = redirect_target; end
        end else begin
            m_uf = 0;
            if (redirect_valid)  m_pc = redirect_target;
            else if (m_pv)       m_pc = m_pt;
            else if (ras_pop) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = p4; m_uf = 1; end
            end else             m_pc = p4;
            m_pv = 0;
            if (ras_push) begin
                m_stk.push_back(p4);
                if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
            end
        end
    endtask

    task automatic clear_inputs();
        reset = 0; preset = 0; trap = 0; stall = 0;
        redirect_valid = 0; ras_push = 0; ras_pop = 0;
        starting_addr = '0; redirect_target = '0;
    endtask

    // Advance one clock with the inputs currently driven, then idle them.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        reset = 1; tick();
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin failures++; $display("FAIL reset_ras got=%b%b exp=10", ras_empty, ras_full); end
        checks++; if (ras_underflow !== 1'b0) begin failures++; $display("FAIL reset_uf got=%b exp=0", ras_underflow); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc_out !== 32'(i * 4)) begin failures++; $display("FAIL free_run pc got=%h exp=%h", pc_out, 32'(i * 4)); end
        end
        checks++; if (pc_plus4 !== 32'h10) begin failures++; $display("FAIL free_run plus4 got=%h exp=%h", pc_plus4, 32'h10); end
    endtask

    task automatic test_ras_calls();
        logic [31:0] exp_pop [4];
        exp_pop = '{32'h34, 32'h24, 32'h14, 32'h18};
        reset = 1; tick();
        redirect_valid = 1; redirect_target = 32'h10; tick();
        for (int i = 0; i < 3; i++) begin
            ras_push = 1; redirect_valid = 1; redirect_target = 32'h20 + 32'(i) * 32'h10; tick();
        end
        checks++; if (pc_out !== 32'h40) begin failures++; $display("FAIL call_pc got=%h exp=%h", pc_out, 32'h40); end
        for (int i = 0; i < 4; i++) begin
            ras_pop = 1; tick();
            checks++; if (pc_out !== exp_pop[i]) begin failures++; $display("FAIL ret_pc[%0d] got=%h exp=%h", i, pc_out, exp_pop[i]); end
        end
        checks++; if (ras_underflow !== 1'b1 || ras_empty !== 1'b1) begin failures++; $display("FAIL underflow got=%b%b exp=11", ras_underflow, ras_empty); end
        tick();
        checks++; if (ras_underflow !== 1'b0) begin failures++; $display("FAIL underflow_pulse got=%b exp=0", ras_underflow); end
    endtask

    task automatic test_stall_redirect();
        reset = 1; tick();
        for (int i = 0; i < 3; i++) begin
            stall = 1; redirect_valid = 1; redirect_target = 32'h200; tick();
            checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL stall_hold got=%h exp=%h", pc_out, 32'h0); end
        end
        tick();
        checks++; if (pc_out !== 32'h200) begin failures++; $display("FAIL pend_apply got=%h exp=%h", pc_out, 32'h200); end
        tick();
        checks++; if (pc_out !== 32'h204) begin failures++; $display("FAIL pend_clear got=%h exp=%h", pc_out, 32'h204); end
        stall = 1; redirect_valid = 1; redirect_target = 32'h280; tick();
        stall = 1; redirect_valid = 1; redirect_target = 32'h2C0; tick();
        tick();
        checks++; if (pc_out !== 32'h2C0) begin failures++; $display("FAIL pend_overwrite got=%h exp=%h", pc_out, 32'h2C0); end
        stall = 1; redirect_valid = 1; redirect_target = 32'h500; tick();
        redirect_valid = 1; redirect_target = 32'h600; tick();
        checks++; if (pc_out !== 32'h600) begin failures++; $display("FAIL fresh_wins got=%h exp=%h", pc_out, 32'h600); end
        tick();
        checks++; if (pc_out !== 32'h604) begin failures++; $display("FAIL fresh_clears got=%h exp=%h", pc_out, 32'h604); end
    endtask

    task automatic test_overflow();
        reset = 1; tick();
        redirect_valid = 1; redirect_target = 32'h1000; tick();
        for (int i = 0; i < 5; i++) begin
            ras_push = 1; redirect_valid = 1; redirect_target = 32'h1100 + 32'(i) * 32'h100; tick();
            if (i == 3) begin
                checks++; if (ras_full !== 1'b1) begin failures++; $display("FAIL full_at4 got=%b exp=1", ras_full); end
            end
        end
        checks++; if (ras_full !== 1'b1) begin failures++; $display("FAIL full_at5 got=%b exp=1", ras_full); end
        for (int i = 0; i < 4; i++) begin
            ras_pop = 1; tick();
            checks++; if (pc_out !== 32'h1404 - 32'(i) * 32'h100) begin failures++; $display("FAIL ovf_pop[%0d] got=%h exp=%h", i, pc_out, 32'h1404 - 32'(i) * 32'h100); end
        end
        checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", ras_empty); end
    endtask

    task automatic test_push_pop_same();
        reset = 1; tick();
        ras_push = 1; tick();
        redirect_valid = 1; redirect_target = 32'h40; tick();
        ras_push = 1; ras_pop = 1; tick();
        checks++; if (pc_out !== 32'h4 || ras_empty !== 1'b0) begin failures++; $display("FAIL pp_nonempty got=%h/%b exp=%h/0", pc_out, ras_empty, 32'h4); end
        ras_pop = 1; tick();
        checks++; if (pc_out !== 32'h44 || ras_empty !== 1'b1) begin failures++; $display("FAIL pp_replaced got=%h/%b exp=%h/1", pc_out, ras_empty, 32'h44); end
        ras_push = 1; ras_pop = 1; tick();
        checks++; if (pc_out !== 32'h48 || ras_underflow !== 1'b1 || ras_empty !== 1'b0) begin failures++; $display("FAIL pp_empty got=%h/%b/%b exp=%h/1/0", pc_out, ras_underflow, ras_empty, 32'h48); end
    endtask

    task automatic test_trap();
        reset = 1; tick();
        stall = 1; redirect_valid = 1; redirect_target = 32'h300; tick();
        trap = 1; stall = 1; tick();
        checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL trap_pc got=%h exp=%h", pc_out, 32'h100); end
        tick();
        checks++; if (pc_out !== 32'h104) begin failures++; $display("FAIL trap_no_pend got=%h exp=%h", pc_out, 32'h104); end
    endtask

    task automatic test_wrap_preset();
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC; tick();
        checks++; if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_plus4 got=%h exp=%h", pc_plus4, 32'h0); end
        tick();
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", pc_out, 32'h0); end
        ras_push = 1; tick();
        preset = 1; starting_addr = 32'h2; tick();
        checks++; if (pc_out !== 32'h2 || misaligned !== 1'b1 || ras_empty !== 1'b1) begin failures++; $display("FAIL preset got=%h/%b/%b exp=%h/1/1", pc_out, misaligned, ras_empty, 32'h2); end
        tick();
        checks++; if (pc_out !== 32'h6 || misaligned !== 1'b1) begin failures++; $display("FAIL misaligned_seq got=%h/%b exp=%h/1", pc_out, misaligned, 32'h6); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) begin ras_push = 1; tick(); end
        stall = 1; redirect_valid = 1; redirect_target = 32'h700; tick();
        reset = 1; stall = 1; tick();
        checks++; if (pc_out !== 32'h0 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin failures++; $display("FAIL mid_reset got=%h/%b%b exp=%h/10", pc_out, ras_empty, ras_full, 32'h0); end
        tick();
        checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL mid_reset_pend got=%h exp=%h", pc_out, 32'h4); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(99) < 1);
            preset         = ($urandom_range(99) < 2);
            starting_addr  = $urandom & 32'hFFFF_FFFC;
            trap           = ($urandom_range(99) < 3);
            stall          = ($urandom_range(99) < 20);
            redirect_valid = ($urandom_range(99) < 20);
            redirect_target = ($urandom_range(9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ras_push       = ($urandom_range(99) < 30);
            ras_pop        = ($urandom_range(99) < 30);
            tick();
            checks++;
            if (pc_out !== m_pc || pc_plus4 !== m_pc + 32'd4 || misaligned !== (m_pc[1:0] != 2'b00) ||
                ras_empty !== (m_stk.size() == 0) || ras_full !== (m_stk.size() == DEPTH) ||
                ras_underflow !== m_uf) begin
                failures++;
                if (bad < 10) $display("FAIL random c=%0d pc=%h/%h e=%b/%b f=%b/%b uf=%b/%b", c,
                    pc_out, m_pc, ras_empty, m_stk.size() == 0, ras_full, m_stk.size() == DEPTH, ras_underflow, m_uf);
                bad++;
            end
        end
    endtask

    initial begin
        clear_inputs();
        m_pc = '0; m_pv = 0; m_pt = '0; m_uf = 0;
        test_reset();
        test_ras_calls();
        test_stall_redirect();
        test_overflow();
        test_push_pop_same();
        test_trap();
        test_wrap_preset();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, width of every address port and internal address register.
REQ-002 Parameter RESET_ADDR, default 0, PC value loaded by reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100, PC value loaded on trap.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 preset  in  1  load starting_addr into PC.
REQ-008 starting_addr  in  XLEN  preset load value.
REQ-009 trap  in  1  force PC to TRAP_VEC.
REQ-010 stall  in  1  hold PC and stack.
REQ-011 redirect_valid  in  1  taken branch/jump this cycle.
REQ-012 redirect_target  in  XLEN  branch/jump destination.
REQ-013 ras_push  in  1  call: push return address.
REQ-014 ras_pop  in  1  return: next PC from stack top.
REQ-015 pc_out  out  XLEN  current PC, registered.
REQ-016 pc_plus4  out  XLEN  pc_out + 4, modulo 2^XLEN, combinational.
REQ-017 misaligned  out  1  high when pc_out[1:0] != 2'b00, combinational.
REQ-018 ras_empty / ras_full  out  1 each  stack occupancy 0 / RAS_DEPTH.
REQ-019 ras_underflow  out  1  one-cycle pulse, registered, on pop attempted while empty.

Function
REQ-020 Next-PC priority, highest first: reset, preset, trap, stall, redirect_valid, pending redirect, ras_pop with stack non-empty, pc_plus4.
REQ-021 preset: PC <= starting_addr; clear pending redirect; stack count <= 0.
REQ-022 trap: PC <= TRAP_VEC even when stall=1; clear pending redirect; stack contents and count unchanged.
REQ-023 stall (no trap/preset): PC holds; no push or pop; if redirect_valid, latch redirect_target into pending register; a later stalled redirect overwrites it.
REQ-024 First non-stalled cycle with pending set: PC <= pending target, pending cleared; a fresh redirect_valid in that cycle wins and also clears pending.
REQ-025 redirect_valid (no stall): PC <= redirect_target; ras_pop ignored, stack not popped.
REQ-026 ras_push (no stall, no trap/preset): write pc_plus4 at top, count += 1; when full, overwrite oldest entry (circular), count stays RAS_DEPTH.
REQ-027 ras_pop selected, stack non-empty: PC <= top entry, count -= 1.
REQ-028 ras_pop selected, stack empty: PC <= pc_plus4, count stays 0, ras_underflow pulses next cycle.
REQ-029 push and pop same cycle, non-empty: PC <= old top; old top replaced by pc_plus4; count unchanged.
REQ-030 push and pop same cycle, empty: PC <= pc_plus4; push performed (count 1); ras_underflow pulses.
REQ-031 PC increment wraps modulo 2^XLEN; no saturation.
REQ-032 misaligned is a flag only; it does not alter PC sequencing.

Reset
REQ-033 reset=1 at a rising edge: pc_out <= RESET_ADDR, count <= 0, pending cleared, ras_underflow <= 0; overrides every other input.
REQ-034 Mid-operation reset (stall, pending or full stack) discards all state within one edge; stack entry contents need not be cleared.
REQ-035 Release: first edge with reset=0 applies normal priority from RESET_ADDR.

Verification
REQ-036 reset, then 3 free-running cycles -> pc_out 0, 4, 8, C.
REQ-037 pc_out=0x10, push at 0x10, 0x20, 0x30 (redirects between) -> pops return 0x34, 0x24, 0x14; fourth pop -> pc_plus4 taken, ras_underflow pulse, ras_empty=1.
REQ-038 stall=1 with redirect_valid to 0x200, held 3 cycles -> pc_out constant; release -> pc_out=0x200 next edge, pending cleared.
REQ-039 RAS_DEPTH=4, 5 pushes of A..E -> ras_full=1; pops return E, D, C, B; then ras_empty=1, A lost.
REQ-040 trap with stall=1 and pending redirect 0x300 -> pc_out=0x100; next cycle no jump to 0x300.
REQ-041 pc_out=0xFFFF_FFFC, no control -> pc_out=0x0000_0000; preset with starting_addr=0x0000_0002 -> pc_out=0x2, misaligned=1.
